mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencer for the multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter and serves MFHI/MFLO reads.
- Raises a stall request to the hazard unit when an MDU instruction in D would collide with an operation still in flight.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  valid MDU instruction in E this cycle.
- mdu_op  input  4  op code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU, 11 MSUB.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- flush  input  1  E-stage instruction cancelled (exception/ERET); qualifies start.
- md_use_d  input  1  instruction in D is any MDU op (1..11).
- busy  output  1  multi-cycle operation in flight.
- stall_req  output  1  freeze F/D, bubble into E.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.
- mf_data  output  32  read data for MFHI/MFLO in E.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE. mf_data=0, stall_req=0 while reset is held.
- Accept condition: acc = start & !flush. With flush=1, the op is dropped entirely: no HI/LO change and no busy.
- States:
  - IDLE -> RUN on acc with op in {1,2,3,4,9,10,11}.
  - RUN -> IDLE when counter reaches 1.
- Entering RUN:
  - Load the counter with MULT_CYCLES or DIV_CYCLES. busy=1 from the next cycle for exactly that many cycles.
  - Compute the full result at accept and hold it in pending_hi/pending_lo.
  - Copy the pending result into hi/lo on the clock edge that ends the last busy cycle (RUN->IDLE). hi/lo keep their old values throughout RUN.
- MTHI/MTLO: single cycle. hi or lo = rs_val at the next edge; busy stays 0.
- MFHI/MFLO: mf_data = hi or lo combinationally. No state change.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}.
  - MULTU: unsigned 32x32 -> 64, {hi,lo}.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - Divisor 0: the op still occupies DIV_CYCLES of busy, but hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_req = md_use_d & (busy | (acc & op in multi-cycle set)).
  - Hazard: the pipeline guarantees start=0 whenever busy=1. If start=1 while busy=1 anyway, it is ignored. Verification flags this as an assertion.
- flush while busy=1 does not cancel the operation. An accepted op always commits (it has passed E).
- Back-to-back ops:
  - An op accepted in the cycle after busy falls starts normally.
  - MFHI in the cycle after busy falls reads the new value.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {hi,lo} += signed rs*rt.
  - MADDU: {hi,lo} += unsigned rs*rt.
  - MSUB: {hi,lo} -= signed rs*rt.
  - All three use MULT_CYCLES. The accumulation is computed from hi/lo at accept time, with 64-bit wrap-around.
- Undefined: ops 9..11 behave as NONE (no busy, no state change). md_use_d is still honoured as presented.

Test Plan:
- Reset mid-RUN: MULT accepted, then reset_n=0 on cycle 3 -> hi=lo=0 and busy=0 immediately; no commit after release.
- MULT rs=0xFFFFFFFF, rt=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 with hi=lo=0x1234 beforehand -> busy 10 cycles; hi=lo=0x1234 after completion.
- Stall hazard: DIV accepted with md_use_d=1 throughout -> stall_req high from the accept cycle through the last busy cycle, low the cycle after. MFLO in that cycle returns the quotient.
- Flush: start=1, flush=1, op MULT -> busy stays 0, hi/lo unchanged. MTHI rs=0xABCD with flush=0 -> hi=0xABCD next cycle; flush asserted during an in-flight MULT -> result still commits.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0 after 5 cycles. Without the macro, the same op leaves hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed latency, requests stalls.
// Optional MADD/MADDU/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd9;
    localparam logic [3:0] OpMaddu = 4'd10;
    localparam logic [3:0] OpMsub  = 4'd11;
`endif

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        acc, multi;
    logic [63:0] prod_s, prod_u;
    logic        div_ovf;
    logic [31:0] sdvsr, udvsr, squo, srem, uquo, urem;

    assign acc = start & ~flush;

    always_comb begin
        multi = 1'b0;
        unique case (mdu_op)
            OpMult, OpMultu, OpDiv, OpDivu: multi = 1'b1;
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu, OpMsub:        multi = 1'b1;
`endif
            default:                        multi = 1'b0;
        endcase
    end

    // Divisors are forced to 1 for x/0 and INT_MIN/-1 so the operators stay well defined.
    always_comb begin
        prod_s  = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u  = {32'h0, rs_val} * {32'h0, rt_val};
        div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
        sdvsr   = ((rt_val == 32'h0) || div_ovf) ? 32'd1 : rt_val;
        udvsr   = (rt_val == 32'h0) ? 32'd1 : rt_val;
        squo    = div_ovf ? 32'h8000_0000 : 32'($signed(rs_val) / $signed(sdvsr));
        srem    = div_ovf ? 32'h0 : 32'($signed(rs_val) % $signed(sdvsr));
        uquo    = rs_val / udvsr;
        urem    = rs_val % udvsr;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    if (multi) begin
                        state_d   = StRun;
                        cnt_d     = 4'(MULT_CYCLES);
                        pend_wr_d = 1'b1;
                    end
                    case (mdu_op)
                        OpMult:  {pend_hi_d, pend_lo_d} = prod_s;
                        OpMultu: {pend_hi_d, pend_lo_d} = prod_u;
                        OpDiv: begin
                            cnt_d     = 4'(DIV_CYCLES);
                            pend_hi_d = srem;
                            pend_lo_d = squo;
                            pend_wr_d = (rt_val != 32'h0);
                        end
                        OpDivu: begin
                            cnt_d     = 4'(DIV_CYCLES);
                            pend_hi_d = urem;
                            pend_lo_d = uquo;
                            pend_wr_d = (rt_val != 32'h0);
                        end
`ifdef MDU_MADD_EN
                        OpMadd:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
                        OpMaddu: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
                        OpMsub:  {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
`endif
                        OpMthi:  hi_d = rs_val;
                        OpMtlo:  lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                // Starts arriving while busy are ignored; flush cannot cancel an accepted op.
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            hi_q      <= 32'h0;
            lo_q      <= 32'h0;
            pend_hi_q <= 32'h0;
            pend_lo_q <= 32'h0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        busy      = (state_q == StRun);
        hi        = hi_q;
        lo        = lo_q;
        stall_req = reset_n & md_use_d & (busy | (acc & multi));
        mf_data   = 32'h0;
        if (reset_n) begin
            if (mdu_op == OpMfhi)      mf_data = hi_q;
            else if (mdu_op == OpMflo) mf_data = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random traffic against a
// timestamp-based reference model of HI/LO, busy window and stall requests.
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        flush = 1'b0;
    logic        md_use_d = 1'b0;
    logic        busy, stall_req;
    logic [31:0] hi, lo, mf_data;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mdu_op(mdu_op),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .md_use_d(md_use_d),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    always #5 clk = ~clk;

    // The bench itself must never issue while an operation is in flight.
    assert property (@(posedge clk) disable iff (!reset_n) !(start && busy))
        else $error("start asserted while busy");

    int n_chk = 0, n_pass = 0;
    int busy_seen = 0, stall_seen = 0;

    // Model: results land at an absolute edge number; busy is "before that edge".
    longint unsigned edge_n = 0, commit_edge = 0;
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
    logic [63:0] p_val = 64'h0;
    bit          p_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_multi(input logic [3:0] op);
        if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
        if (op >= 4'd9 && op <= 4'd11) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output bit wr, output logic [63:0] r);
        wr = 1'b1;
        r  = {m_hi, m_lo};
        case (op)
            4'd1: r = 64'(sx(a) * sx(b));
            4'd2: r = {32'h0, a} * {32'h0, b};
            4'd3: if (b == 0) wr = 1'b0;
                  else r = {32'(sx(a) % sx(b)), 32'(sx(a) / sx(b))};
            4'd4: if (b == 0) wr = 1'b0;
                  else r = {a % b, a / b};
`ifdef MDU_MADD_EN
            4'd9:  r = {m_hi, m_lo} + 64'(sx(a) * sx(b));
            4'd10: r = {m_hi, m_lo} + {32'h0, a} * {32'h0, b};
            4'd11: r = {m_hi, m_lo} - 64'(sx(a) * sx(b));
`endif
            default: ;
        endcase
    endtask

    task automatic cycle(input logic s, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic f, input logic md);
        bit mbusy, macc, wr;
        logic [63:0] r;
        logic [31:0] emf;
        start = s; mdu_op = op; rs_val = a; rt_val = b; flush = f; md_use_d = md;
        @(negedge clk);
        mbusy = (edge_n < commit_edge);
        macc  = s & ~f;
        emf   = !reset_n ? 32'h0 : (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'h0;
        check("busy", 32'(busy), 32'(mbusy));
        check("stall_req", 32'(stall_req), 32'(reset_n & md & (mbusy | (macc & is_multi(op)))));
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("mf_data", mf_data, emf);
        if (busy) busy_seen++;
        if (stall_req) stall_seen++;
        @(posedge clk);
        if (reset_n) begin
            edge_n++;
            if (edge_n == commit_edge && p_wr) {m_hi, m_lo} = p_val;
            if (macc && !mbusy) begin
                if (is_multi(op)) begin
                    compute(op, a, b, wr, r);
                    p_wr = wr;
                    p_val = r;
                    commit_edge = edge_n + longint'((op == 4'd3 || op == 4'd4) ? DC : MC);
                end else if (op == 4'd5) m_hi = a;
                else if (op == 4'd6) m_lo = a;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic f, input logic md, input logic fd);
        busy_seen = 0;
        stall_seen = 0;
        cycle(1'b1, op, a, b, f, md);
        while (edge_n < commit_edge) cycle(1'b0, 4'd0, 32'h0, 32'h0, fd, md);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 32'h0; m_lo = 32'h0; p_wr = 1'b0; commit_edge = edge_n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] sv_hi, sv_lo;
        // Reset held: outputs quiet even with an MDU op and md_use_d presented.
        cycle(1'b1, 4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
        cycle(1'b1, 4'd7, 32'd3, 32'd4, 1'b0, 1'b1);
        check("rst_stall", 32'(stall_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hi", hi, 32'h0);
        reset_n = 1'b1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        check("mult_busy_len", busy_seen, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check("div_busy_len", busy_seen, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        cycle(1'b1, 4'd5, 32'h1234, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 32'h1234, 32'h0, 1'b0, 1'b0);
        issue(4'd4, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        check("divu0_busy_len", busy_seen, 32'd10);
        check("divu0_hi", hi, 32'h1234);
        check("divu0_lo", lo, 32'h1234);

        issue(4'd3, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        check("stall_len", stall_seen, 32'd11);
        cycle(1'b1, 4'd8, 32'h0, 32'h0, 1'b0, 1'b1);
        check("mflo_after_div", mf_data, 32'd14);
        check("stall_after_busy", 32'(stall_req), 32'h0);

        sv_hi = hi; sv_lo = lo;
        cycle(1'b1, 4'd1, 32'd5, 32'd5, 1'b1, 1'b0);
        check("flush_busy", 32'(busy), 32'h0);
        check("flush_hi", hi, sv_hi);
        check("flush_lo", lo, sv_lo);
        cycle(1'b1, 4'd5, 32'hABCD, 32'h0, 1'b0, 1'b0);
        check("mthi", hi, 32'hABCD);
        issue(4'd1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        check("flush_inflight_lo", lo, 32'd12);
        check("flush_inflight_hi", hi, 32'd0);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        cycle(1'b1, 4'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        issue(4'd10, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
        check("maddu_busy_len", busy_seen, 32'd5);
        check("maddu_hi", hi, 32'd1);
        check("maddu_lo", lo, 32'd0);
`else
        check("maddu_busy_len", busy_seen, 32'd0);
        check("maddu_hi", hi, 32'd0);
        check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset in the third busy cycle of a MULT.
        cycle(1'b1, 4'd6, 32'd5, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 4'd1, 32'd7, 32'd7, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rstrun_busy", 32'(busy), 32'h0);
        check("rstrun_lo", lo, 32'h0);
        check("rstrun_hi", hi, 32'h0);
        model_reset();
        cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'd8, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rstrun_nocommit", lo, 32'h0);

        for (int i = 0; i < 500; i++) begin
            logic s;
            s = (edge_n < commit_edge) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
            cycle(s, 4'($urandom_range(0, 12)), rand_word(), rand_word(),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
